mac_simd_fu: RTL and testbench
==============================

# mac_simd_fu

Parametrised packed-SIMD dot-product functional unit for the CVA6 execute stage, alongside ALU/MULT. It splits `operand_a`/`operand_b` into `NUM_LANES` lanes of `LANE_W` bits and multiplies lane-wise under a per-instruction signedness mode. It reduces the products through an adder tree and optionally adds an accumulator, in a fixed 3-cycle, fully pipelined flow. It generalises the 8-bit signed×unsigned dot unit: configurable lane width, three signedness modes, accumulate, and flush-aware valid tracking.

## Interface
Parameters:
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: core configuration; XLEN taken as `riscv::XLEN` (32 or 64).
- `LANE_W`, 8: lane width; legal values 4, 8, 16; elaboration `$fatal` otherwise.
- `NUM_LANES`, `riscv::XLEN/LANE_W`: derived; not overridden.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low; clock `clk_i`.
- `flush_i`  in  1  pipeline flush; kills all in-flight and entering ops.
- `mac_valid_i`  in  1  issue strobe for this FU.
- `fu_data_i`  in  `fu_data_t`  operation, `operand_a`, `operand_b`, `imm` (accumulator, rs3 forwarded by issue), `trans_id`.
- `mac_ready_o`  out  1  constant 1.
- `mac_valid_o`  out  1  result valid, single-cycle pulse per op.
- `mac_result_o`  out  XLEN  result.
- `mac_trans_id_o`  out  TRANS_ID_BITS  tag of result.
- `mac_exception_o`  out  `exception_t`  constant '0.

## Operation
- Decode `fu_data_i.operation` into a mode:
  - `DOT_SU`: A signed, B unsigned.
  - `DOT_SS`: both signed.
  - `DOT_UU`: both unsigned.
  - `DOTA_SU`, `DOTA_SS`, `DOTA_UU`: same signedness as the matching `DOT_*`, plus accumulate with `imm`.
  - Any other op is treated as `DOT_SU`.
- Stage 1 (multiply):
  - Each lane operand is extended to `LANE_W+1` bits, sign or zero per mode.
  - Each product is signed, `2*LANE_W+2` bits.
  - Registered together with `acc_en`, `imm`, `trans_id` and `valid = mac_valid_i & ~flush_i`.
- Stage 2 (reduce):
  - Combinational adder tree over `NUM_LANES` products, width `2*LANE_W+2+$clog2(NUM_LANES)`.
  - The sum is sign-extended or truncated to `XLEN+1` bits, then registered.
- Stage 3 (accumulate):
  - Computed as `sum + (acc_en ? signed'(imm) : 0)` at `XLEN+1` bits.
  - The result is narrowed to XLEN as set under Configuration, then registered.
- Valid chain: every stage's valid input is ANDed with `~flush_i`.
- `flush_i` kills:
  - the op entering in that cycle;
  - every op in stages 1–3, which then never asserts `mac_valid_o`.
- Data and tag registers load every cycle. Content is only meaningful when valid.

## Timing
- Latency: an op issued in cycle N gives `mac_valid_o=1` in cycle N+3.
- Throughput: 1 op/cycle, no stalls, no backpressure (`mac_ready_o=1` always).
- Results leave in issue order.
- Reset values:
  - `mac_valid_o` = 0, `mac_result_o` = 0, `mac_trans_id_o` = 0.
  - All internal stage registers are cleared.
- Reset mid-operation: all in-flight ops are discarded. The first valid output after reset release is N+3 of the first post-reset issue.
- Flush with simultaneous issue: the issued op is dropped. An op issued the cycle after the flush proceeds normally.
- Overflow: `LANE_W=16` with XLEN=32 can exceed 32 bits. Handling is set under Configuration.

## Configuration
- `MAC_SIMD_SAT_EN` defined: the stage-3 `XLEN+1`-bit result saturates to signed XLEN.
  - Clamps to `0x7FFF…` or `0x8000…`.
- `MAC_SIMD_SAT_EN` undefined: the result wraps modulo 2^XLEN (low XLEN bits kept).

## Structure
- Shared in `ariane_pkg`:
  - new `fu_op` enum values `DOT_SU`, `DOT_SS`, `DOT_UU`, `DOTA_SU`, `DOTA_SS`, `DOTA_UU`;
  - `fu_t` value `MAC_SIMD`.
- Local package `mac_simd_pkg` holds:
  - `mac_mode_t`: `a_signed`, `b_signed`, `acc_en`;
  - the decode function from `fu_op`;
  - width constants.
- One sub-module, `mac_simd_lane`: parametrised `LANE_W` multiplier with signedness inputs, instantiated `NUM_LANES` times.
- The adder tree stays in the top level.

## Test plan
All vectors use XLEN=32, `LANE_W=8`. Lane 0 is the LSB byte.
- `DOT_SU`, a=0xFF010203, b=0x04030201 → `mac_result_o`=0x00000006 at N+3.
- `DOT_UU` a=b=0xFFFFFFFF → 0x0003F804. `DOT_SS` same operands → 0x00000004.
- `DOTA_SU`, a=b=0x01010101, imm=0x7FFFFFFF → 0x7FFFFFFF with `MAC_SIMD_SAT_EN`, 0x80000003 without.
- Issue trans_id 1..8 in consecutive cycles → valid in 8 consecutive cycles, ids 1..8 in order.
- Issue in cycles 0, 1, 2 with `flush_i` in cycle 2 → no valid output at all. Op issued in cycle 3 → valid in cycle 6.
- Assert `rst_ni`=0 in cycle 1 with two ops in flight → outputs 0 and no valid until N+3 of the next issue after release.

Source files
------------

// File: rtl/cva6_core_pkg.sv
// Minimal slice of the shared CVA6 packages used by the packed-SIMD MAC unit:
// core configuration, ISA width, functional-unit opcodes and issue/exception
// payload types.

package config_pkg;

    // Core configuration record; XLEN of 0 means "not specified".
    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd0};

endpackage

package riscv;

    localparam int unsigned XLEN = 32'd32;

endpackage

package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 32'd4;

    typedef enum logic [7:0] {
        ADD     = 8'd0,
        SUB     = 8'd1,
        MUL     = 8'd2,
        DOT_SU  = 8'd3,
        DOT_SS  = 8'd4,
        DOT_UU  = 8'd5,
        DOTA_SU = 8'd6,
        DOTA_SS = 8'd7,
        DOTA_UU = 8'd8
    } fu_op;

    typedef enum logic [3:0] {
        NONE     = 4'd0,
        LOAD     = 4'd1,
        STORE    = 4'd2,
        ALU      = 4'd3,
        CTRL_FLOW = 4'd4,
        MULT     = 4'd5,
        CSR      = 4'd6,
        MAC_SIMD = 4'd7
    } fu_t;

    typedef struct packed {
        fu_op                      operation;
        logic [riscv::XLEN-1:0]    operand_a;
        logic [riscv::XLEN-1:0]    operand_b;
        logic [riscv::XLEN-1:0]    imm;
        logic [TRANS_ID_BITS-1:0]  trans_id;
    } fu_data_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;

endpackage

// File: rtl/mac_simd_pkg.sv
// Local package of the packed-SIMD dot-product unit: per-instruction mode
// record, opcode decode and shared widths.

package mac_simd_pkg;

    import ariane_pkg::*;

    localparam int unsigned MAC_XLEN  = riscv::XLEN;
    localparam int unsigned MAC_RES_W = MAC_XLEN + 32'd1;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
        logic acc_en;
    } mac_mode_t;

    // Unknown opcodes fall back to the signed x unsigned dot product.
    function automatic mac_mode_t decode_mode(input fu_op op);
        mac_mode_t m;
        m = '{a_signed: 1'b1, b_signed: 1'b0, acc_en: 1'b0};
        case (op)
            DOT_SU:  m = '{a_signed: 1'b1, b_signed: 1'b0, acc_en: 1'b0};
            DOT_SS:  m = '{a_signed: 1'b1, b_signed: 1'b1, acc_en: 1'b0};
            DOT_UU:  m = '{a_signed: 1'b0, b_signed: 1'b0, acc_en: 1'b0};
            DOTA_SU: m = '{a_signed: 1'b1, b_signed: 1'b0, acc_en: 1'b1};
            DOTA_SS: m = '{a_signed: 1'b1, b_signed: 1'b1, acc_en: 1'b1};
            DOTA_UU: m = '{a_signed: 1'b0, b_signed: 1'b0, acc_en: 1'b1};
            default: m = '{a_signed: 1'b1, b_signed: 1'b0, acc_en: 1'b0};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mac_simd_lane.sv
// One SIMD lane multiplier: each operand is widened by one bit (sign or zero
// per its signedness flag) so every mode fits one signed multiply.

module mac_simd_lane #(
    parameter int unsigned LANE_W = 8
) (
    input  logic                       a_signed,
    input  logic                       b_signed,
    input  logic [LANE_W-1:0]          a,
    input  logic [LANE_W-1:0]          b,
    output logic signed [2*LANE_W+1:0] prod
);

    localparam int unsigned PROD_W = 2 * LANE_W + 2;

    logic [LANE_W:0]   a_ext_s;
    logic [LANE_W:0]   b_ext_s;
    logic [PROD_W-1:0] a_wide_s;
    logic [PROD_W-1:0] b_wide_s;

    assign a_ext_s  = {a_signed & a[LANE_W-1], a};
    assign b_ext_s  = {b_signed & b[LANE_W-1], b};
    assign a_wide_s = {{(PROD_W-LANE_W-1){a_ext_s[LANE_W]}}, a_ext_s};
    assign b_wide_s = {{(PROD_W-LANE_W-1){b_ext_s[LANE_W]}}, b_ext_s};
    assign prod     = $signed(a_wide_s) * $signed(b_wide_s);

endmodule

// File: rtl/mac_simd_fu.sv
// Packed-SIMD dot-product functional unit, 3-cycle fully pipelined:
// multiply lanes -> reduce -> accumulate/narrow. Flush kills every op in flight.
// Build option MAC_SIMD_SAT_EN: saturate the result to signed XLEN instead of
// wrapping modulo 2^XLEN.

module mac_simd_fu
    import ariane_pkg::*;
    import mac_simd_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned NUM_LANES = riscv::XLEN / LANE_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      mac_valid_i,
    input  fu_data_t                  fu_data_i,
    output logic                      mac_ready_o,
    output logic                      mac_valid_o,
    output logic [riscv::XLEN-1:0]    mac_result_o,
    output logic [TRANS_ID_BITS-1:0]  mac_trans_id_o,
    output exception_t                mac_exception_o
);

    localparam int unsigned XLEN   = MAC_XLEN;
    localparam int unsigned PROD_W = 2 * LANE_W + 2;
    localparam int unsigned SUM_W  = PROD_W + $clog2(NUM_LANES);

    if (LANE_W != 32'd4 && LANE_W != 32'd8 && LANE_W != 32'd16) begin : g_bad_lane_w
        $fatal(1, "mac_simd_fu: LANE_W must be 4, 8 or 16");
    end
    if (CVA6Cfg.XLEN != 32'd0 && CVA6Cfg.XLEN != XLEN) begin : g_bad_xlen
        $fatal(1, "mac_simd_fu: configuration XLEN disagrees with riscv::XLEN");
    end

    assign mac_ready_o     = 1'b1;
    assign mac_exception_o = '0;

    mac_mode_t mode_s;
    assign mode_s = decode_mode(fu_data_i.operation);

    // ---------------- stage 1: lane multipliers ----------------
    logic signed [PROD_W-1:0] prod_s    [NUM_LANES];
    logic signed [PROD_W-1:0] s1_prod_r [NUM_LANES];
    logic                     s1_valid_r;
    logic                     s1_acc_en_r;
    logic [XLEN-1:0]          s1_imm_r;
    logic [TRANS_ID_BITS-1:0] s1_trans_id_r;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        mac_simd_lane #(.LANE_W(LANE_W)) u_lane (
            .a_signed (mode_s.a_signed),
            .b_signed (mode_s.b_signed),
            .a        (fu_data_i.operand_a[k*LANE_W +: LANE_W]),
            .b        (fu_data_i.operand_b[k*LANE_W +: LANE_W]),
            .prod     (prod_s[k])
        );
    end

    // Stage-1 register: lane products plus the op's sideband.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_r    <= 1'b0;
            s1_acc_en_r   <= 1'b0;
            s1_imm_r      <= '0;
            s1_trans_id_r <= '0;
            for (int k = 0; k < NUM_LANES; k++) s1_prod_r[k] <= '0;
        end else begin
            s1_valid_r    <= mac_valid_i & ~flush_i;
            s1_acc_en_r   <= mode_s.acc_en;
            s1_imm_r      <= fu_data_i.imm;
            s1_trans_id_r <= fu_data_i.trans_id;
            for (int k = 0; k < NUM_LANES; k++) s1_prod_r[k] <= prod_s[k];
        end
    end

    // ---------------- stage 2: reduction ----------------
    logic signed [SUM_W-1:0] sum_s;
    logic [MAC_RES_W-1:0]    sum_res_s;
    logic                    s2_valid_r;
    logic                    s2_acc_en_r;
    logic [XLEN-1:0]         s2_imm_r;
    logic [TRANS_ID_BITS-1:0] s2_trans_id_r;
    logic [MAC_RES_W-1:0]    s2_sum_r;

    // Sum of all sign-extended lane products; synthesis balances it into a tree.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            sum_s = sum_s + {{(SUM_W-PROD_W){s1_prod_r[k][PROD_W-1]}}, s1_prod_r[k]};
        end
    end

    if (SUM_W >= MAC_RES_W) begin : g_sum_trunc
        logic [SUM_W-1:0] unused_sum_hi_s;
        assign unused_sum_hi_s = sum_s;
        assign sum_res_s       = sum_s[MAC_RES_W-1:0];
    end else begin : g_sum_sext
        assign sum_res_s = {{(MAC_RES_W-SUM_W){sum_s[SUM_W-1]}}, sum_s};
    end

    // Stage-2 register: reduced sum at XLEN+1 bits plus sideband.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_r    <= 1'b0;
            s2_acc_en_r   <= 1'b0;
            s2_imm_r      <= '0;
            s2_trans_id_r <= '0;
            s2_sum_r      <= '0;
        end else begin
            s2_valid_r    <= s1_valid_r & ~flush_i;
            s2_acc_en_r   <= s1_acc_en_r;
            s2_imm_r      <= s1_imm_r;
            s2_trans_id_r <= s1_trans_id_r;
            s2_sum_r      <= sum_res_s;
        end
    end

    // ---------------- stage 3: accumulate and narrow ----------------
    logic [MAC_RES_W-1:0] acc_s;
    logic [MAC_RES_W-1:0] acc_sum_s;
    logic [XLEN-1:0]      narrow_s;

    // Add the sign-extended accumulator for DOTA_* ops.
    always_comb begin
        acc_s = '0;
        if (s2_acc_en_r) begin
            acc_s = {s2_imm_r[XLEN-1], s2_imm_r};
        end else begin
            acc_s = '0;
        end
        acc_sum_s = s2_sum_r + acc_s;
    end

`ifdef MAC_SIMD_SAT_EN
    // Clamp to signed XLEN when the two top bits disagree.
    always_comb begin
        narrow_s = acc_sum_s[XLEN-1:0];
        if (acc_sum_s[XLEN] != acc_sum_s[XLEN-1]) begin
            if (acc_sum_s[XLEN]) begin
                narrow_s = {1'b1, {(XLEN-1){1'b0}}};
            end else begin
                narrow_s = {1'b0, {(XLEN-1){1'b1}}};
            end
        end else begin
            narrow_s = acc_sum_s[XLEN-1:0];
        end
    end
`else
    // Wrapping keeps the low XLEN bits; the extra top bit is dropped.
    logic unused_wrap_msb_s;
    assign unused_wrap_msb_s = acc_sum_s[XLEN];
    assign narrow_s          = acc_sum_s[XLEN-1:0];
`endif

    // Output register: single-cycle valid pulse with result and tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mac_valid_o    <= 1'b0;
            mac_result_o   <= '0;
            mac_trans_id_o <= '0;
        end else begin
            mac_valid_o    <= s2_valid_r & ~flush_i;
            mac_result_o   <= narrow_s;
            mac_trans_id_o <= s2_trans_id_r;
        end
    end

endmodule

// File: tb/tb_mac_simd_fu.sv
// Directed self-checking bench for mac_simd_fu (XLEN=32, LANE_W=8).

module tb_mac_simd_fu;

    import ariane_pkg::*;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic                      flush_i;
    logic                      mac_valid_i;
    fu_data_t                  fu_data_i;
    logic                      mac_ready_o;
    logic                      mac_valid_o;
    logic [31:0]               mac_result_o;
    logic [TRANS_ID_BITS-1:0]  mac_trans_id_o;
    exception_t                mac_exception_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mac_simd_fu #(.LANE_W(8)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .mac_valid_i     (mac_valid_i),
        .fu_data_i       (fu_data_i),
        .mac_ready_o     (mac_ready_o),
        .mac_valid_o     (mac_valid_o),
        .mac_result_o    (mac_result_o),
        .mac_trans_id_o  (mac_trans_id_o),
        .mac_exception_o (mac_exception_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input fu_op op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [3:0] id);
        mac_valid_i         = v;
        fu_data_i.operation = op;
        fu_data_i.operand_a = a;
        fu_data_i.operand_b = b;
        fu_data_i.imm       = imm;
        fu_data_i.trans_id  = id;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, DOT_SU, 32'h0, 32'h0, 32'h0, 4'h0);
        step();
        step();
        checks++;
        if (mac_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", mac_valid_o);
        end
        checks++;
        if (mac_result_o !== 32'h0) begin
            failures++; $display("FAIL reset_result: got %h expected 00000000", mac_result_o);
        end
        checks++;
        if (mac_trans_id_o !== 4'h0) begin
            failures++; $display("FAIL reset_id: got %h expected 0", mac_trans_id_o);
        end
        checks++;
        if (mac_ready_o !== 1'b1) begin
            failures++; $display("FAIL ready: got %b expected 1", mac_ready_o);
        end
        checks++;
        if (mac_exception_o !== '0) begin
            failures++; $display("FAIL exception: got %h expected 0", mac_exception_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_dot_modes();
        fu_op        ops [10];
        logic [31:0] as  [10];
        logic [31:0] bs  [10];
        logic [31:0] ims [10];
        logic [31:0] exps[10];
        ops[0] = DOT_SU;  as[0] = 32'hFF010203; bs[0] = 32'h04030201; ims[0] = 32'h0;        exps[0] = 32'h00000006;
        ops[1] = DOT_UU;  as[1] = 32'hFFFFFFFF; bs[1] = 32'hFFFFFFFF; ims[1] = 32'h0;        exps[1] = 32'h0003F804;
        ops[2] = DOT_SS;  as[2] = 32'hFFFFFFFF; bs[2] = 32'hFFFFFFFF; ims[2] = 32'h0;        exps[2] = 32'h00000004;
        ops[3] = DOT_SU;  as[3] = 32'hFFFFFFFF; bs[3] = 32'hFFFFFFFF; ims[3] = 32'h12345678; exps[3] = 32'hFFFFFC04;
        ops[4] = DOTA_SS; as[4] = 32'hFFFFFFFF; bs[4] = 32'hFFFFFFFF; ims[4] = 32'hFFFFFFF0; exps[4] = 32'hFFFFFFF4;
        ops[5] = ADD;     as[5] = 32'hFF010203; bs[5] = 32'h04030201; ims[5] = 32'h0;        exps[5] = 32'h00000006;
        ops[6] = DOTA_SU; as[6] = 32'h01010101; bs[6] = 32'h01010101; ims[6] = 32'h7FFFFFFF;
`ifdef MAC_SIMD_SAT_EN
        exps[6] = 32'h7FFFFFFF;
`else
        exps[6] = 32'h80000003;
`endif
        ops[7] = DOTA_UU; as[7] = 32'h80808080; bs[7] = 32'h02020202; ims[7] = 32'h00000010; exps[7] = 32'h00000410;
        ops[8] = DOT_SS;  as[8] = 32'h80808080; bs[8] = 32'h7F7F7F7F; ims[8] = 32'h0;        exps[8] = 32'hFFFF0200;
        ops[9] = DOT_SU;  as[9] = 32'h7F7F7F7F; bs[9] = 32'h80808080; ims[9] = 32'h0;        exps[9] = 32'h0000FE00;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ops[i], as[i], bs[i], ims[i], 4'(i + 1));
            step();
            drive(1'b0, DOT_SU, 32'h0, 32'h0, 32'h0, 4'h0);
            for (int c = 1; c <= 4; c++) begin
                if (c == 3) begin
                    checks++;
                    if (mac_valid_o !== 1'b1) begin
                        failures++; $display("FAIL vec%0d_valid: got %b expected 1", i, mac_valid_o);
                    end
                    checks++;
                    if (mac_result_o !== exps[i]) begin
                        failures++; $display("FAIL vec%0d_result: got %h expected %h", i, mac_result_o, exps[i]);
                    end
                    checks++;
                    if (mac_trans_id_o !== 4'(i + 1)) begin
                        failures++; $display("FAIL vec%0d_id: got %h expected %h", i, mac_trans_id_o, 4'(i + 1));
                    end
                end else begin
                    checks++;
                    if (mac_valid_o !== 1'b0) begin
                        failures++; $display("FAIL vec%0d_idle_c%0d: got valid %b expected 0", i, c, mac_valid_o);
                    end
                end
                step();
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            if (c >= 3 && c <= 10) begin
                checks++;
                if (mac_valid_o !== 1'b1) begin
                    failures++; $display("FAIL b2b_valid_c%0d: got %b expected 1", c, mac_valid_o);
                end
                checks++;
                if (mac_trans_id_o !== 4'(c - 2)) begin
                    failures++; $display("FAIL b2b_id_c%0d: got %h expected %h", c, mac_trans_id_o, 4'(c - 2));
                end
                checks++;
                if (mac_result_o !== 32'(c - 2)) begin
                    failures++; $display("FAIL b2b_result_c%0d: got %h expected %h", c, mac_result_o, 32'(c - 2));
                end
            end else begin
                checks++;
                if (mac_valid_o !== 1'b0) begin
                    failures++; $display("FAIL b2b_idle_c%0d: got valid %b expected 0", c, mac_valid_o);
                end
            end
            if (c < 8) drive(1'b1, DOT_UU, 32'(c + 1), 32'h01010101, 32'h0, 4'(c + 1));
            else       drive(1'b0, DOT_SU, 32'h0, 32'h0, 32'h0, 4'h0);
            step();
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (mac_valid_o !== (c == 6)) begin
                failures++; $display("FAIL flush_valid_c%0d: got %b expected %b", c, mac_valid_o, (c == 6));
            end
            if (c == 6) begin
                checks++;
                if (mac_result_o !== 32'h5 || mac_trans_id_o !== 4'hA) begin
                    failures++;
                    $display("FAIL flush_post_op: got result %h id %h expected 00000005 a", mac_result_o, mac_trans_id_o);
                end
            end
            flush_i = (c == 2);
            if (c <= 2)      drive(1'b1, DOT_SU, 32'hFF010203, 32'h04030201, 32'h0, 4'(c + 1));
            else if (c == 3) drive(1'b1, DOT_UU, 32'h00000005, 32'h01010101, 32'h0, 4'hA);
            else             drive(1'b0, DOT_SU, 32'h0, 32'h0, 32'h0, 4'h0);
            step();
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, DOT_UU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'h1);
        step();
        drive(1'b1, DOT_UU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'h2);
        step();
        drive(1'b0, DOT_SU, 32'h0, 32'h0, 32'h0, 4'h0);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (mac_valid_o !== 1'b0 || mac_result_o !== 32'h0 || mac_trans_id_o !== 4'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got valid %b result %h id %h expected 0 0 0", mac_valid_o, mac_result_o, mac_trans_id_o);
        end
        step();
        step();
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (mac_valid_o !== 1'b0) begin
                failures++; $display("FAIL rst_mid_idle_c%0d: got valid %b expected 0", c, mac_valid_o);
            end
            step();
        end
        drive(1'b1, DOT_SU, 32'hFF010203, 32'h04030201, 32'h0, 4'h3);
        step();
        drive(1'b0, DOT_SU, 32'h0, 32'h0, 32'h0, 4'h0);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (mac_valid_o !== 1'b0) begin
                failures++; $display("FAIL rst_mid_wait_c%0d: got valid %b expected 0", c, mac_valid_o);
            end
            step();
        end
        checks++;
        if (mac_valid_o !== 1'b1 || mac_result_o !== 32'h6 || mac_trans_id_o !== 4'h3) begin
            failures++;
            $display("FAIL rst_mid_first_op: got valid %b result %h id %h expected 1 00000006 3", mac_valid_o, mac_result_o, mac_trans_id_o);
        end
    endtask

    initial begin
        test_reset();
        test_dot_modes();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
